// File: rtl/reg_wb_pkg.sv
// Shared widths and the write-port selection encoding for the register-file
// writeback arbiter.
package reg_wb_pkg;

   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 1 << ADDR_W;

   // Which source owns the register-file write port in a given cycle.
   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_PIPE = 2'd1,
      SEL_MDU  = 2'd2
   } sel_t;

   // r0 is hardwired to zero, so writes to it are never performed.
   function automatic logic is_r0(input logic [ADDR_W-1:0] addr);
      return (addr == {ADDR_W{1'b0}});
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding MDU results ({addr, data}) until the write
// port is free. Flags come straight from the registered occupancy count.
module wb_fifo
   import reg_wb_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int AW    = ADDR_W,
   parameter int DW    = DATA_W
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [AW-1:0] push_addr_i,
   input  logic [DW-1:0] push_data_i,
   input  logic          pop_i,
   output logic [AW-1:0] head_addr_o,
   output logic [DW-1:0] head_data_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [AW+DW-1:0] mem_q [DEPTH];
   logic [AW+DW-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full_o      = (count_q == FULL_CNT);
   assign empty_o     = (count_q == {CNT_W{1'b0}});
   assign head_addr_o = mem_q[rd_ptr_q][AW+DW-1:DW];
   assign head_data_o = mem_q[rd_ptr_q][DW-1:0];

   // Next-state for storage, pointers and occupancy; overflow/underflow are blocked here too.
   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      push_ok_s = push_i & ~full_o;
      pop_ok_s  = pop_i & ~empty_o;

      if (push_ok_s) begin
         mem_d[wr_ptr_q] = {push_addr_i, push_data_i};
         wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_ok_s) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO state registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {(AW + DW){1'b0}};
         end
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Merges pipeline WB and queued MDU results onto the single register-file
// write port, forces a one-cycle pipeline stall when the MDU queue starves,
// and tracks outstanding MDU destinations for decode hazard detection.
module reg_wb_arbiter
   import reg_wb_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              pipe_we_i,
   input  logic [ADDR_W-1:0] pipe_addr_i,
   input  logic [DATA_W-1:0] pipe_data_i,
   input  logic              mdu_valid_i,
   input  logic [ADDR_W-1:0] mdu_addr_i,
   input  logic [DATA_W-1:0] mdu_data_i,
   output logic              mdu_ready_o,
   input  logic              issue_i,
   input  logic [ADDR_W-1:0] issue_addr_i,
   input  logic [ADDR_W-1:0] rs_addr_i,
   input  logic [ADDR_W-1:0] rt_addr_i,
   output logic              hazard_o,
   output logic              stall_o,
   output logic              error_o,
   output logic              RegWrite_o,
   output logic [ADDR_W-1:0] RDaddr_o,
   output logic [DATA_W-1:0] RDdata_o
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   sel_t              sel_s;
   logic              push_s;
   logic              pop_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic [ADDR_W-1:0] head_addr_s;
   logic [DATA_W-1:0] head_data_s;

   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              stall_q, stall_d;
   logic              error_q, error_d;
   logic [CNT_W-1:0]  starve_q, starve_d;
   logic [NUM_REGS-1:0] busy_q, busy_d;

   wb_fifo #(
      .DEPTH (DEPTH),
      .AW    (ADDR_W),
      .DW    (DATA_W)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push_s),
      .push_addr_i (mdu_addr_i),
      .push_data_i (mdu_data_i),
      .pop_i       (pop_s),
      .head_addr_o (head_addr_s),
      .head_data_o (head_data_s),
      .full_o      (fifo_full_s),
      .empty_o     (fifo_empty_s)
   );

   // Ready depends only on the registered occupancy, never on mdu_valid_i.
   assign mdu_ready_o = ~fifo_full_s;
   assign push_s      = mdu_valid_i & ~fifo_full_s;
   assign pop_s       = (sel_s == SEL_MDU);

   assign hazard_o    = busy_q[rs_addr_i] | busy_q[rt_addr_i];
   assign stall_o     = stall_q;
   assign error_o     = error_q;
   assign RegWrite_o  = we_q;
   assign RDaddr_o    = addr_q;
   assign RDdata_o    = data_q;

   // Pick the write-port owner: pipeline first unless stalled, else the FIFO head.
   always_comb begin
      sel_s = SEL_NONE;
      if (!stall_q && pipe_we_i && !is_r0(pipe_addr_i)) begin
         sel_s = SEL_PIPE;
      end else if (!fifo_empty_s) begin
         sel_s = SEL_MDU;
      end else begin
         sel_s = SEL_NONE;
      end
   end

   // Next values of the write-port registers; idle slots present zeros.
   always_comb begin
      we_d   = 1'b0;
      addr_d = {ADDR_W{1'b0}};
      data_d = {DATA_W{1'b0}};
      case (sel_s)
         SEL_PIPE: begin
            we_d   = 1'b1;
            addr_d = pipe_addr_i;
            data_d = pipe_data_i;
         end
         SEL_MDU: begin
            // An r0 result still pops, but produces no write.
            if (!is_r0(head_addr_s)) begin
               we_d   = 1'b1;
               addr_d = head_addr_s;
               data_d = head_data_s;
            end else begin
               we_d   = 1'b0;
               addr_d = {ADDR_W{1'b0}};
               data_d = {DATA_W{1'b0}};
            end
         end
         default: begin
            we_d   = 1'b0;
            addr_d = {ADDR_W{1'b0}};
            data_d = {DATA_W{1'b0}};
         end
      endcase
   end

   // Starvation counting, the one-cycle forced stall, and the sticky protocol error.
   always_comb begin
      starve_d = starve_q;
      stall_d  = 1'b0;
      error_d  = error_q;

      if (stall_q || fifo_empty_s || pop_s) begin
         starve_d = {CNT_W{1'b0}};
      end else if ((sel_s == SEL_PIPE) && (starve_q != STARVE_LIM)) begin
         starve_d = starve_q + CNT_W'(1);
      end else begin
         starve_d = starve_q;
      end

      stall_d = (starve_d == STARVE_LIM);

      // The pipeline must not request a write while it is being held.
      if (stall_q && pipe_we_i) begin
         error_d = 1'b1;
      end else begin
         error_d = error_q;
      end
   end

   // Busy scoreboard: pop clears the head destination, issue sets; set wins on a tie.
   always_comb begin
      busy_d = busy_q;
      if (pop_s && !is_r0(head_addr_s)) begin
         busy_d[head_addr_s] = 1'b0;
      end else begin
         busy_d = busy_q;
      end
      if (issue_i && !is_r0(issue_addr_i)) begin
         busy_d[issue_addr_i] = 1'b1;
      end else begin
         busy_d[0] = 1'b0;
      end
      busy_d[0] = 1'b0;
   end

   // Registered outputs, starve counter and scoreboard.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         we_q     <= 1'b0;
         addr_q   <= {ADDR_W{1'b0}};
         data_q   <= {DATA_W{1'b0}};
         stall_q  <= 1'b0;
         error_q  <= 1'b0;
         starve_q <= {CNT_W{1'b0}};
         busy_q   <= {NUM_REGS{1'b0}};
      end else begin
         we_q     <= we_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         stall_q  <= stall_d;
         error_q  <= error_d;
         starve_q <= starve_d;
         busy_q   <= busy_d;
      end
   end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: a vector table for single-cycle
// behaviour plus hand-written sequences for starvation, full FIFO,
// error stickiness and reset in the middle of traffic.
module tb_reg_wb_arbiter;

   logic        clk_i;
   logic        rst_i;
   logic        pipe_we_i;
   logic [4:0]  pipe_addr_i;
   logic [31:0] pipe_data_i;
   logic        mdu_valid_i;
   logic [4:0]  mdu_addr_i;
   logic [31:0] mdu_data_i;
   logic        mdu_ready_o;
   logic        issue_i;
   logic [4:0]  issue_addr_i;
   logic [4:0]  rs_addr_i;
   logic [4:0]  rt_addr_i;
   logic        hazard_o;
   logic        stall_o;
   logic        error_o;
   logic        RegWrite_o;
   logic [4:0]  RDaddr_o;
   logic [31:0] RDdata_o;

   int n_checks = 0;
   int n_fail   = 0;

   reg_wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .pipe_we_i    (pipe_we_i),
      .pipe_addr_i  (pipe_addr_i),
      .pipe_data_i  (pipe_data_i),
      .mdu_valid_i  (mdu_valid_i),
      .mdu_addr_i   (mdu_addr_i),
      .mdu_data_i   (mdu_data_i),
      .mdu_ready_o  (mdu_ready_o),
      .issue_i      (issue_i),
      .issue_addr_i (issue_addr_i),
      .rs_addr_i    (rs_addr_i),
      .rt_addr_i    (rt_addr_i),
      .hazard_o     (hazard_o),
      .stall_o      (stall_o),
      .error_o      (error_o),
      .RegWrite_o   (RegWrite_o),
      .RDaddr_o     (RDaddr_o),
      .RDdata_o     (RDdata_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        pwe;
      logic [4:0]  paddr;
      logic [31:0] pdata;
      logic        mv;
      logic [4:0]  maddr;
      logic [31:0] mdata;
      logic        iss;
      logic [4:0]  iaddr;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        e_we;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      logic        e_haz;
   } vec_t;

   function automatic vec_t mk(
      input logic pwe, input logic [4:0] paddr, input logic [31:0] pdata,
      input logic mv, input logic [4:0] maddr, input logic [31:0] mdata,
      input logic iss, input logic [4:0] iaddr,
      input logic [4:0] rs, input logic [4:0] rt,
      input logic e_we, input logic [4:0] e_addr, input logic [31:0] e_data,
      input logic e_haz);
      vec_t v;
      v.pwe = pwe;  v.paddr = paddr;  v.pdata = pdata;
      v.mv = mv;    v.maddr = maddr;  v.mdata = mdata;
      v.iss = iss;  v.iaddr = iaddr;  v.rs = rs;  v.rt = rt;
      v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data; v.e_haz = e_haz;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic we, input logic [4:0] addr,
                          input logic [31:0] data, input logic stall, input logic err,
                          input logic rdy, input logic haz);
      chk({tag, ".we"},    {31'd0, RegWrite_o},  {31'd0, we});
      chk({tag, ".addr"},  {27'd0, RDaddr_o},    {27'd0, addr});
      chk({tag, ".data"},  RDdata_o,             data);
      chk({tag, ".stall"}, {31'd0, stall_o},     {31'd0, stall});
      chk({tag, ".err"},   {31'd0, error_o},     {31'd0, err});
      chk({tag, ".rdy"},   {31'd0, mdu_ready_o}, {31'd0, rdy});
      chk({tag, ".haz"},   {31'd0, hazard_o},    {31'd0, haz});
   endtask

   task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md,
                        input logic iss, input logic [4:0] ia,
                        input logic [4:0] rs, input logic [4:0] rt);
      pipe_we_i = pwe;  pipe_addr_i = pa;  pipe_data_i = pd;
      mdu_valid_i = mv; mdu_addr_i = ma;   mdu_data_i = md;
      issue_i = iss;    issue_addr_i = ia; rs_addr_i = rs; rt_addr_i = rt;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   vec_t vecs[20];
   logic exp_stall;

   initial begin
      rst_i = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);

      // Table: each row is held for one cycle, outputs compared just after the edge.
      //          pwe   pa     pdata         mv    ma     mdata         iss   ia     rs     rt     we    addr   data          haz
      vecs[0]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0);
      vecs[1]  = mk(1'b1, 5'd3,  32'h1111_1111, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 5'd3,  32'h1111_1111, 1'b0);
      vecs[2]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  5'd0,  1'b0, 5'd0,  32'h0,        1'b1);
      vecs[3]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'hDEAD_BEEF, 1'b0, 5'd0,  5'd7,  5'd0,  1'b0, 5'd0,  32'h0,        1'b1);
      vecs[4]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd0,  1'b1, 5'd7,  32'hDEAD_BEEF, 1'b0);
      vecs[5]  = mk(1'b1, 5'd0,  32'h55,       1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0);
      vecs[6]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h66,       1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0);
      vecs[7]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0);
      vecs[8]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  5'd0,  5'd4,  1'b0, 5'd0,  32'h0,        1'b1);
      vecs[9]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'h44,       1'b0, 5'd0,  5'd0,  5'd4,  1'b0, 5'd0,  32'h0,        1'b1);
      vecs[10] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  5'd0,  5'd4,  1'b1, 5'd4,  32'h44,       1'b1);
      vecs[11] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd4,  1'b0, 5'd0,  32'h0,        1'b1);
      vecs[12] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'h45,       1'b0, 5'd0,  5'd0,  5'd4,  1'b0, 5'd0,  32'h0,        1'b1);
      vecs[13] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd4,  1'b1, 5'd4,  32'h45,       1'b0);
      vecs[14] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 5'd10, 5'd4,  1'b0, 5'd0,  32'h0,        1'b1);
      vecs[15] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 5'd3,  5'd12, 1'b0, 5'd0,  32'h0,        1'b1);
      vecs[16] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd5,  1'b0, 5'd0,  32'h0,        1'b0);
      vecs[17] = mk(1'b1, 5'd3,  32'h33,       1'b1, 5'd10, 32'hAA,       1'b0, 5'd0,  5'd10, 5'd0,  1'b1, 5'd3,  32'h33,       1'b1);
      vecs[18] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd10, 5'd0,  1'b1, 5'd10, 32'hAA,       1'b0);
      vecs[19] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd12, 5'd0,  1'b0, 5'd0,  32'h0,        1'b1);

      // Power-on reset.
      repeat (2) tick();
      chk_all("por", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      rst_i = 1'b1;

      for (int i = 0; i < 20; i++) begin
         drive(vecs[i].pwe, vecs[i].paddr, vecs[i].pdata, vecs[i].mv, vecs[i].maddr,
               vecs[i].mdata, vecs[i].iss, vecs[i].iaddr, vecs[i].rs, vecs[i].rt);
         tick();
         chk_all($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_addr, vecs[i].e_data,
                 1'b0, 1'b0, 1'b1, vecs[i].e_haz);
      end

      // Starvation: continuous pipe writes to r3, one MDU result for r9.
      drive(1'b1, 5'd3, 32'h3333_0000, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();
      chk_all("starve.push", 1'b1, 5'd3, 32'h3333_0000, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 5'd3, 32'h3333_0000, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         exp_stall = (i == 4);
         chk_all($sformatf("starve.pipe%0d", i), 1'b1, 5'd3, 32'h3333_0000, exp_stall, 1'b0, 1'b1, 1'b0);
      end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();
      chk_all("starve.mdu", 1'b1, 5'd9, 32'h99, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 5'd3, 32'h3333_0001, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();
      chk_all("starve.resume", 1'b1, 5'd3, 32'h3333_0001, 1'b0, 1'b0, 1'b1, 1'b0);

      // Full FIFO: three results for r20/r21/r22 while the pipe writes.
      drive(1'b1, 5'd3, 32'hD0, 1'b1, 5'd20, 32'hA0, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();
      chk_all("full.d0", 1'b1, 5'd3, 32'hD0, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 5'd3, 32'hD0, 1'b1, 5'd21, 32'hA1, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();
      chk_all("full.d1", 1'b1, 5'd3, 32'hD0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 5'd3, 32'hD0, 1'b1, 5'd22, 32'hA2, 1'b0, 5'd0, 5'd0, 5'd0);
      for (int i = 2; i <= 4; i++) begin
         tick();
         exp_stall = (i == 4);
         chk_all($sformatf("full.d%0d", i), 1'b1, 5'd3, 32'hD0, exp_stall, 1'b0, 1'b0, 1'b0);
      end
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd22, 32'hA2, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();
      chk_all("full.pop20", 1'b1, 5'd20, 32'hA0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_all("full.pop21", 1'b1, 5'd21, 32'hA1, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();
      chk_all("full.pop22", 1'b1, 5'd22, 32'hA2, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_all("full.empty", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Pipe keeps writing through the forced stall: error becomes sticky.
      drive(1'b1, 5'd3, 32'hE0, 1'b1, 5'd11, 32'hB, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();
      chk_all("err.push", 1'b1, 5'd3, 32'hE0, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 5'd3, 32'hE0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         exp_stall = (i == 4);
         chk_all($sformatf("err.pipe%0d", i), 1'b1, 5'd3, 32'hE0, exp_stall, 1'b0, 1'b1, 1'b0);
      end
      tick();
      chk_all("err.set", 1'b1, 5'd11, 32'hB, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();
      chk_all("err.r0", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();
      chk_all("err.sticky", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);

      // Reset mid-operation: FIFO holding two results and busy[5] set.
      drive(1'b1, 5'd3, 32'hF0, 1'b1, 5'd20, 32'hA0, 1'b1, 5'd5, 5'd5, 5'd0);
      tick();
      chk_all("rst.f0", 1'b1, 5'd3, 32'hF0, 1'b0, 1'b1, 1'b1, 1'b1);
      drive(1'b1, 5'd3, 32'hF0, 1'b1, 5'd21, 32'hA1, 1'b0, 5'd0, 5'd5, 5'd0);
      tick();
      chk_all("rst.f1", 1'b1, 5'd3, 32'hF0, 1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
      #2;
      rst_i = 1'b0;
      #1;
      chk_all("rst.async", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_all("rst.held", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      rst_i = 1'b1;
      tick();
      chk_all("rst.after1", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_all("rst.after2", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-port arbiter and scoreboard for the 32x32 register file. It merges two writeback sources onto the single write port: the in-order pipeline WB stage and the multi-cycle multiply/divide unit (MDU). The pipeline is never back-pressured, so MDU results queue in a small FIFO and drain into idle write slots. A per-register busy scoreboard lets decode detect RAW hazards against outstanding MDU destinations.

## Interface
- DEPTH, 2, MDU result FIFO entries (≥1)
- STARVE_MAX, 4, consecutive lost cycles with non-empty FIFO before a forced pipeline stall
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

- clk_i  in  1  clock; all state on posedge
- rst_i  in  1  asynchronous, active-low reset
- pipe_we_i  in  1  pipeline WB write request
- pipe_addr_i  in  ADDR_W  pipeline WB destination
- pipe_data_i  in  DATA_W  pipeline WB data
- mdu_valid_i  in  1  MDU result valid
- mdu_addr_i  in  ADDR_W  MDU destination
- mdu_data_i  in  DATA_W  MDU result
- mdu_ready_o  out  1  FIFO can accept (= !full)
- issue_i  in  1  MDU op issued this cycle
- issue_addr_i  in  ADDR_W  destination of issued MDU op
- rs_addr_i, rt_addr_i  in  ADDR_W  decode source operands
- hazard_o  out  1  busy[rs] | busy[rt], combinational
- stall_o  out  1  registered; pipeline must hold WB bubble this cycle
- error_o  out  1  sticky: pipeline wrote while stall_o=1
- RegWrite_o  out  1  registered write enable to register file
- RDaddr_o  out  ADDR_W  registered write address
- RDdata_o  out  DATA_W  registered write data

## Operation
- Reset values: RegWrite_o=0, RDaddr_o=0, RDdata_o=0, stall_o=0, error_o=0, mdu_ready_o=1, hazard_o=0; FIFO empty; busy all 0; starve counter 0.
- MDU push: mdu_valid_i && mdu_ready_o. No push when full. Push and pop in the same cycle are legal.
- Selection each cycle:
  - If stall_o=0 and pipe_we_i && pipe_addr_i≠0: SEL_PIPE.
  - Else if FIFO non-empty: SEL_MDU, which pops the head.
  - Else: SEL_NONE.
- During stall_o=1, the FIFO head wins. A concurrent pipe_we_i is dropped and error_o is set; only reset clears it.
- Address 0: pipe writes to r0 are ignored and never win. An MDU head with address 0 pops, drives RegWrite_o=0, and clears nothing.
- Starve counter:
  - Increments when the FIFO is non-empty and SEL_PIPE wins.
  - Cleared on any pop or when the FIFO is empty.
  - Reaching STARVE_MAX sets stall_o for exactly the next cycle, then the counter clears.
- Scoreboard busy[31:1]:
  - issue_i sets busy[issue_addr_i]; address 0 is ignored.
  - An MDU pop clears busy[head addr].
  - Simultaneous set and clear of the same address: set wins.
  - Issue to an already busy register is legal; the bit stays set.

## Timing
- Selection is made in cycle t. RegWrite_o/RDaddr_o/RDdata_o reflect it at t+1 for one cycle. The register file captures on the negedge within t+1.
- busy clears on the same edge that presents the MDU write, so hazard_o falls in t+1.
- Minimum MDU latency, push to RegWrite_o: 2 cycles when the FIFO is empty and the pipe is idle.
- mdu_ready_o derives from registered FIFO count only, with no combinational path from mdu_valid_i.
- Worst-case MDU wait, FIFO head: STARVE_MAX+2 cycles.

## Structure
- Package reg_wb_pkg holds ADDR_W, DATA_W, and the enum sel_t {SEL_NONE, SEL_PIPE, SEL_MDU}.
- Sub-module wb_fifo: DEPTH-entry synchronous FIFO with {addr,data} entries, full/empty flags, and the same clock/reset.
- Top module: selection logic, output registers, starve counter, stall/error flags, and the scoreboard.

## Test plan
- Reset mid-operation (FIFO holding 2, busy[5] set) -> next cycle: all outputs at reset values, mdu_ready_o=1, hazard_o=0.
- Idle pipe; MDU push r7=0xDEADBEEF at t -> RegWrite_o=1, RDaddr_o=7, RDdata_o=0xDEADBEEF at t+2; busy[7] 1→0 on the same edge.
- pipe_we_i continuous (r3); MDU push r9 -> 4 cycles of pipe writes, stall_o=1 one cycle, r9 written next, error_o=0 with the pipe idle during stall.
- FIFO full (DEPTH=2) with pipe writing -> mdu_ready_o=0; third result held by MDU until first pop; no loss, original order preserved.
- issue_i r4; rs_addr_i=4 -> hazard_o=1 until the r4 MDU write is presented; issue and pop of r4 in the same cycle leaves busy[4]=1.
- pipe write to r0 and MDU result to r0 -> no RegWrite_o pulse for either; FIFO drains; pipe_we_i during stall_o -> error_o=1 sticky.
